reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry RV32I integer register file that sits directly upstream of the ALU.
- Read port 1 drives ALU op1. Read port 2 drives the op2 mux (register operand).
- Write port 3 receives writeback data: ALU result or load data.
- Also exports a0 (x10) as a debug/observation output for top-level testbenches.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the pre-write value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ad1  input  ADDR_WIDTH  read address, port 1 (rs1).
- ad2  input  ADDR_WIDTH  read address, port 2 (rs2).
- ad3  input  ADDR_WIDTH  write address (rd).
- we3  input  1  write enable.
- wd3  input  DATA_WIDTH  write data.
- rd1  output  DATA_WIDTH  read data, port 1 (to ALU op1).
- rd2  output  DATA_WIDTH  read data, port 2 (to op2 mux).
- a0  output  DATA_WIDTH  continuous view of register x10.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Reset:
  - rst high at a rising edge clears every register to 0.
  - After that edge: rd1 = rd2 = 0 for any address, and a0 = 0.
  - Reset has priority: a write presented in the same cycle as rst is discarded.
- Write:
  - When we3 = 1 and rst = 0, the register at ad3 takes wd3 at the rising edge.
  - Write latency is 1 cycle; the new value is visible in the stored array from the next cycle.
- x0:
  - Writes to ad3 = 0 are ignored; register 0 stays 0 permanently.
  - Reading address 0 returns 0 under all conditions, including BYPASS forwarding.
- Read:
  - Combinational, zero latency: rd1 = reg[ad1], rd2 = reg[ad2].
  - No clock or enable involvement.
- Read-during-write, same cycle, we3 = 1, ad3 == adN, ad3 != 0:
  - BYPASS = 1: rdN = wd3 combinationally.
  - BYPASS = 0: rdN = old stored value; the new value appears in the next cycle.
  - Each read port is evaluated independently; both ports may forward at once.
- we3 = 0: ad3 and wd3 are don't-care; no state change.
- a0:
  - Driven from the stored reg[10] only, never bypassed.
  - Changes exactly one edge after a write to x10.
- Width rules:
  - Addresses use the full ADDR_WIDTH with no aliasing.
  - Data is stored unmodified; no sign or zero extension in this block.
- Reset mid-operation: any pending write is lost, and contents before the reset edge are irrelevant afterwards.
- No X on outputs after the first reset edge.

Test Plan:
1. Reset then read:
   - Preload x5 = 0xDEADBEEF, pulse rst for 1 cycle.
   - Then ad1 = 5, ad2 = 10 -> rd1 = 0x00000000, rd2 = 0, a0 = 0.
2. Basic write/read:
   - Write we3 = 1, ad3 = 3, wd3 = 0x00000007; next cycle write ad3 = 4, wd3 = 0xFFFFFFF9.
   - Then ad1 = 3, ad2 = 4 -> rd1 = 0x00000007, rd2 = 0xFFFFFFF9.
   - A testbench ALU add of these gives 0x00000000 with eq = 0.
3. x0 protection:
   - we3 = 1, ad3 = 0, wd3 = 0x12345678, with ad1 = 0 in the same cycle -> rd1 = 0 in that cycle and in all later cycles.
4. Bypass:
   - BYPASS = 1: x7 = 0x11; drive we3 = 1, ad3 = 7, wd3 = 0x22, ad1 = ad2 = 7 -> rd1 = rd2 = 0x22 in the same cycle.
   - BYPASS = 0: same stimulus -> rd1 = rd2 = 0x11 in that cycle, 0x22 in the next.
5. a0 timing and reset priority:
   - Write ad3 = 10, wd3 = 0xA5A5A5A5 -> a0 = 0xA5A5A5A5 starting one edge later, not during the write cycle.
   - Then assert rst together with we3 = 1, ad3 = 10, wd3 = 0x1 -> a0 = 0 after that edge.
6. we3 low:
   - x9 = 0x55; drive we3 = 0, ad3 = 9, wd3 = 0xAA for 3 cycles -> ad1 = 9 gives rd1 = 0x55 throughout.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry RV32I integer register file feeding the ALU.
// Two combinational read ports, one write port, x10 exported as a0.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ad1,
  input  logic [ADDR_WIDTH-1:0] ad2,
  input  logic [ADDR_WIDTH-1:0] ad3,
  input  logic                  we3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic wr_en;
  logic fwd1;
  logic fwd2;

  // A write only lands when not in reset and not aimed at x0
  assign wr_en = we3 && !rst && (ad3 != '0);
  assign fwd1  = BYPASS && wr_en && (ad3 == ad1);
  assign fwd2  = BYPASS && wr_en && (ad3 == ad2);

  // Storage update: reset clears everything and wins over a write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[ad3] <= wd3;
    end
  end

  // Port 1 read: x0 hard-wired to zero, optional same-cycle forward
  always_comb begin
    rd1 = '0;
    if (ad1 != '0) begin
      rd1 = fwd1 ? wd3 : regs[ad1];
    end
  end

  // Port 2 read: same rules as port 1, evaluated independently
  always_comb begin
    rd2 = '0;
    if (ad2 != '0) begin
      rd2 = fwd2 ? wd3 : regs[ad2];
    end
  end

  // a0 tracks stored x10 only, so it moves one edge after a write
  assign a0 = regs[A0_IDX];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Runs a forwarding and a non-forwarding instance side by side.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ad1, ad2, ad3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1_b, rd2_b, a0_b;
  logic [31:0] rd1_n, rd2_n, a0_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] r1b;
    logic [31:0] r2b;
    logic [31:0] r1n;
    logic [31:0] r2n;
    logic [31:0] a0;
  } exp_t;

  exp_t        sbq [$];
  exp_t        e;
  logic [31:0] mdl [32];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .we3(we3), .wd3(wd3),
    .rd1(rd1_b), .rd2(rd2_b), .a0(a0_b)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .we3(we3), .wd3(wd3),
    .rd1(rd1_n), .rd2(rd2_n), .a0(a0_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we3 && !rst && ad3 == a) return wd3;
    return mdl[a];
  endfunction

  // Drive one cycle of stimulus, queue its expectation, go to negedge
  task automatic drive(input logic r, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3,
                       input logic w, input logic [31:0] d);
    exp_t x;
    rst = r; ad1 = a1; ad2 = a2; ad3 = a3; we3 = w; wd3 = d;
    #0;
    x.r1b = exp_rd(a1, 1'b1);
    x.r2b = exp_rd(a2, 1'b1);
    x.r1n = exp_rd(a1, 1'b0);
    x.r2n = exp_rd(a2, 1'b0);
    x.a0  = mdl[10];
    sbq.push_back(x);
    @(negedge clk);
  endtask

  // Take the rising edge and update the reference contents
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (we3 && ad3 != 5'd0) begin
      mdl[ad3] = wd3;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF);
    void'(sbq.pop_front());
    advance();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    void'(sbq.pop_front());
    advance();
    drive(1'b0, 5'd5, 5'd10, 5'd0, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (rd1_b !== 32'h0) begin
      bad++; $display("FAIL rst_rd1_b got=%h exp=%h", rd1_b, 32'h0);
    end
    total++;
    if (rd2_b !== e.r2b) begin
      bad++; $display("FAIL rst_rd2_b got=%h exp=%h", rd2_b, e.r2b);
    end
    total++;
    if (a0_b !== 32'h0) begin
      bad++; $display("FAIL rst_a0_b got=%h exp=%h", a0_b, 32'h0);
    end
    total++;
    if (rd1_n !== e.r1n) begin
      bad++; $display("FAIL rst_rd1_n got=%h exp=%h", rd1_n, e.r1n);
    end
    total++;
    if (a0_n !== e.a0) begin
      bad++; $display("FAIL rst_a0_n got=%h exp=%h", a0_n, e.a0);
    end
    advance();
  endtask

  task automatic test_write();
    logic [31:0] sum;
    drive(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'h00000007);
    void'(sbq.pop_front());
    advance();
    drive(1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 32'hFFFFFFF9);
    void'(sbq.pop_front());
    advance();
    drive(1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (rd1_b !== e.r1b) begin
      bad++; $display("FAIL wr_rd1_b got=%h exp=%h", rd1_b, e.r1b);
    end
    total++;
    if (rd2_b !== 32'hFFFFFFF9) begin
      bad++; $display("FAIL wr_rd2_b got=%h exp=%h", rd2_b, 32'hFFFFFFF9);
    end
    total++;
    if (rd1_n !== 32'h00000007) begin
      bad++; $display("FAIL wr_rd1_n got=%h exp=%h", rd1_n, 32'h7);
    end
    total++;
    if (rd2_n !== e.r2n) begin
      bad++; $display("FAIL wr_rd2_n got=%h exp=%h", rd2_n, e.r2n);
    end
    sum = rd1_b + rd2_b;
    total++;
    if (sum !== 32'h0) begin
      bad++; $display("FAIL alu_add got=%h exp=%h", sum, 32'h0);
    end
    total++;
    if ((rd1_b == rd2_b) !== 1'b0) begin
      bad++; $display("FAIL alu_eq got=%b exp=0", rd1_b == rd2_b);
    end
    advance();
  endtask

  task automatic test_x0();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h12345678);
    e = sbq.pop_front();
    total++;
    if (rd1_b !== 32'h0) begin
      bad++; $display("FAIL x0_same_b got=%h exp=%h", rd1_b, 32'h0);
    end
    total++;
    if (rd1_n !== e.r1n) begin
      bad++; $display("FAIL x0_same_n got=%h exp=%h", rd1_n, e.r1n);
    end
    advance();
    drive(1'b0, 5'd0, 5'd0, 5'd1, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (rd1_b !== 32'h0) begin
      bad++; $display("FAIL x0_later_b got=%h exp=%h", rd1_b, 32'h0);
    end
    total++;
    if (rd2_n !== e.r2n) begin
      bad++; $display("FAIL x0_later_n got=%h exp=%h", rd2_n, e.r2n);
    end
    advance();
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 32'h11);
    void'(sbq.pop_front());
    advance();
    drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 32'h22);
    e = sbq.pop_front();
    total++;
    if (rd1_b !== 32'h22) begin
      bad++; $display("FAIL byp_rd1_b got=%h exp=%h", rd1_b, 32'h22);
    end
    total++;
    if (rd2_b !== e.r2b) begin
      bad++; $display("FAIL byp_rd2_b got=%h exp=%h", rd2_b, e.r2b);
    end
    total++;
    if (rd1_n !== 32'h11) begin
      bad++; $display("FAIL nobyp_rd1 got=%h exp=%h", rd1_n, 32'h11);
    end
    total++;
    if (rd2_n !== e.r2n) begin
      bad++; $display("FAIL nobyp_rd2 got=%h exp=%h", rd2_n, e.r2n);
    end
    advance();
    drive(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (rd1_n !== 32'h22) begin
      bad++; $display("FAIL nobyp_next1 got=%h exp=%h", rd1_n, 32'h22);
    end
    total++;
    if (rd2_n !== e.r2n) begin
      bad++; $display("FAIL nobyp_next2 got=%h exp=%h", rd2_n, e.r2n);
    end
    advance();
  endtask

  task automatic test_a0();
    drive(1'b0, 5'd10, 5'd0, 5'd10, 1'b1, 32'hA5A5A5A5);
    e = sbq.pop_front();
    total++;
    if (a0_b !== e.a0) begin
      bad++; $display("FAIL a0_during_b got=%h exp=%h", a0_b, e.a0);
    end
    total++;
    if (rd1_b !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL a0_fwd_rd1 got=%h exp=%h", rd1_b, 32'hA5A5A5A5);
    end
    advance();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (a0_b !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL a0_after_b got=%h exp=%h", a0_b, 32'hA5A5A5A5);
    end
    total++;
    if (a0_n !== e.a0) begin
      bad++; $display("FAIL a0_after_n got=%h exp=%h", a0_n, e.a0);
    end
    advance();
    drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'h1);
    void'(sbq.pop_front());
    advance();
    drive(1'b0, 5'd10, 5'd3, 5'd0, 1'b0, 32'h0);
    e = sbq.pop_front();
    total++;
    if (a0_b !== 32'h0) begin
      bad++; $display("FAIL rstprio_a0_b got=%h exp=%h", a0_b, 32'h0);
    end
    total++;
    if (a0_n !== e.a0) begin
      bad++; $display("FAIL rstprio_a0_n got=%h exp=%h", a0_n, e.a0);
    end
    total++;
    if (rd2_b !== e.r2b) begin
      bad++; $display("FAIL rstprio_rd2 got=%h exp=%h", rd2_b, e.r2b);
    end
    advance();
  endtask

  task automatic test_we_low();
    drive(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 32'h55);
    void'(sbq.pop_front());
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 32'hAA);
      e = sbq.pop_front();
      total++;
      if (rd1_b !== 32'h55) begin
        bad++; $display("FAIL we_low_b c=%0d got=%h exp=%h", c, rd1_b, 32'h55);
      end
      total++;
      if (rd1_n !== e.r1n) begin
        bad++; $display("FAIL we_low_n c=%0d got=%h exp=%h", c, rd1_n, e.r1n);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom);
      e = sbq.pop_front();
      total++;
      if (rd1_b !== e.r1b) begin
        bad++; $display("FAIL b2b_rd1_b c=%0d got=%h exp=%h", c, rd1_b, e.r1b);
      end
      total++;
      if (rd2_b !== e.r2b) begin
        bad++; $display("FAIL b2b_rd2_b c=%0d got=%h exp=%h", c, rd2_b, e.r2b);
      end
      total++;
      if (rd1_n !== e.r1n) begin
        bad++; $display("FAIL b2b_rd1_n c=%0d got=%h exp=%h", c, rd1_n, e.r1n);
      end
      total++;
      if (rd2_n !== e.r2n) begin
        bad++; $display("FAIL b2b_rd2_n c=%0d got=%h exp=%h", c, rd2_n, e.r2n);
      end
      total++;
      if (a0_b !== e.a0 || a0_n !== e.a0) begin
        bad++; $display("FAIL b2b_a0 c=%0d got=%h/%h exp=%h", c, a0_b, a0_n, e.a0);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 'x;
    rst = 1'b0; ad1 = '0; ad2 = '0; ad3 = '0; we3 = 1'b0; wd3 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_write();
    test_x0();
    test_bypass();
    test_a0();
    test_we_low();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
